mmio_counter_bank: RTL

Parametrised bank of memory-mapped event counters for the RISC-V core's memory stage. It replaces the fixed cycle, instruction, branch and accuracy counters with NUM_CNT counters of CNT_W bits. Counters are read by loads and cleared selectively by a store to a reset address. Read data is registered so it arrives with the same one-cycle latency as DMEM and lines up with the writeback mux.

---
 rtl/mmio_counter_bank_pkg.sv | 35 +++
 rtl/mmio_counter_bank_if.sv | 13 +
 rtl/mmio_counter.sv | 27 ++
 rtl/mmio_counter_bank.sv | 109 ++++++++++
 4 files changed

// File: rtl/mmio_counter_bank_pkg.sv
// Shared memory map and read-decode helper for the MMIO counter bank.
// Memory-stage control imports this package so its decode matches the bank's.
package mmio_counter_bank_pkg;

  localparam logic [31:0] MMIO_RST_ADDR = 32'h8000_0018;
  localparam logic [31:0] MMIO_CNT_BASE = 32'h8000_0040;

  typedef enum logic [3:0] {
    CNT_CYCLE   = 4'd0,
    CNT_INST    = 4'd1,
    CNT_BRANCH  = 4'd2,
    CNT_CORRECT = 4'd3
  } cnt_id_e;

  typedef struct packed {
    logic       hit;
    logic       hi;
    logic [3:0] idx;
  } rd_dec_t;

  // The offset is unsigned, so an address below the base wraps high and misses.
  function automatic rd_dec_t decode_rd(input logic [31:0] addr, input logic [31:0] base,
                                        input int unsigned num_cnt,
                                        input int unsigned cnt_bytes);
    logic [31:0] off;
    rd_dec_t     d;
    d     = '0;
    off   = addr - base;
    d.hit = (addr[1:0] == 2'b00) && (off < num_cnt * cnt_bytes);
    d.idx = (cnt_bytes == 8) ? off[6:3] : off[5:2];
    d.hi  = (cnt_bytes == 8) && off[2];
    return d;
  endfunction

endpackage

// File: rtl/mmio_counter_bank_if.sv
// Memory-stage access bus into the counter bank: address, load/store strobes,
// store data, and the registered read return.
interface mmio_counter_bank_if;
  logic [31:0] mem_addr;
  logic        ld_en;
  logic        st_en;
  logic [31:0] st_data;
  logic [31:0] rd_data;
  logic        rd_hit;

  modport master (output mem_addr, ld_en, st_en, st_data, input rd_data, rd_hit);
  modport slave  (input mem_addr, ld_en, st_en, st_data, output rd_data, rd_hit);
endinterface

// File: rtl/mmio_counter.sv
// Single free-running event counter; a clear in the same cycle as an
// increment wins, so the counter lands on zero.
module mmio_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mmio_counter_bank.sv
// Bank of NUM_CNT read-only MMIO counters with selective clear and a registered read port.
// MMIO_CNT_HI_LATCH_EN (CNT_W=64 only) adds a shadow making low-then-high reads tear-free.
module mmio_counter_bank
  import mmio_counter_bank_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned NUM_CNT  = 4,
  parameter logic [31:0] CNT_BASE = MMIO_CNT_BASE,
  parameter logic [31:0] RST_ADDR = MMIO_RST_ADDR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_CNT-1:0] i_cnt_inc,
  mmio_counter_bank_if.slave bus
);

  localparam int unsigned CNT_BYTES = CNT_W / 8;

  rd_dec_t            w_dec;
  logic               w_rd_hit;
  logic               w_clr_hit;
  logic [NUM_CNT-1:0] w_clr_mask;
  logic [NUM_CNT-1:0] w_clr;
  logic [CNT_W-1:0]   w_cnt [NUM_CNT];
  logic [CNT_W-1:0]   w_sel;
  logic [31:0]        w_word;
  logic               w_unused;
  logic [31:0]        r_rd_data;
  logic               r_rd_hit;

  assign w_dec     = decode_rd(bus.mem_addr, CNT_BASE, NUM_CNT, CNT_BYTES);
  assign w_rd_hit  = bus.ld_en & w_dec.hit;
  assign w_clr_hit = bus.st_en && (bus.mem_addr == RST_ADDR);
  // An all-zero mask clears everything so legacy "store 0" software still works.
  assign w_clr_mask = (bus.st_data[NUM_CNT-1:0] == '0) ? '1 : bus.st_data[NUM_CNT-1:0];
  assign w_clr      = w_clr_hit ? w_clr_mask : '0;
  assign w_unused   = ^{bus.st_data, w_dec.hi};

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    mmio_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (i_cnt_inc[gi]),
      .i_clr (w_clr[gi]),
      .o_cnt (w_cnt[gi])
    );
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_dec.idx == 4'(i)) w_sel = w_cnt[i];
    end
  end

  if (CNT_W == 64) begin : g_w64
`ifdef MMIO_CNT_HI_LATCH_EN
    logic [31:0] r_shadow;
    logic [3:0]  r_shadow_idx;
    logic        r_shadow_vld;
    logic        w_shadow_clr;
    logic        w_shadow_use;

    always_comb begin
      w_shadow_clr = 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_clr[i] && (r_shadow_idx == 4'(i))) w_shadow_clr = 1'b1;
      end
    end

    assign w_shadow_use = r_shadow_vld && (r_shadow_idx == w_dec.idx);

    // A low-word load capturing the shadow takes priority over a clear of the held counter.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_shadow     <= '0;
        r_shadow_idx <= '0;
        r_shadow_vld <= 1'b0;
      end else if (w_rd_hit && !w_dec.hi) begin
        r_shadow     <= w_sel[63:32];
        r_shadow_idx <= w_dec.idx;
        r_shadow_vld <= 1'b1;
      end else if (w_shadow_clr) begin
        r_shadow <= '0;
      end
    end

    assign w_word = !w_dec.hi ? w_sel[31:0] : (w_shadow_use ? r_shadow : w_sel[63:32]);
`else
    assign w_word = w_dec.hi ? w_sel[63:32] : w_sel[31:0];
`endif
  end else begin : g_w32
    assign w_word = w_sel[31:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_rd_hit  <= 1'b0;
    end else begin
      r_rd_hit <= w_rd_hit;
      if (w_rd_hit) r_rd_data <= w_word;
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.rd_hit  = r_rd_hit;

endmodule
